// File: rtl/bus_pkg.sv
// Shared definitions for the SRAM bus time-slicer: owner encoding, slot/phase
// indices within the 16-cycle frame.
package bus_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_VIDEO = 2'd1,
    OWNER_SPI   = 2'd2,
    OWNER_CPU   = 2'd3
  } owner_t;

  localparam logic [1:0] SLOT_VIDEO0 = 2'd0;
  localparam logic [1:0] SLOT_1      = 2'd1;
  localparam logic [1:0] SLOT_SPI    = 2'd2;
  localparam logic [1:0] SLOT_CPU    = 2'd3;

  localparam logic [1:0] PHASE_SETUP        = 2'd0;
  localparam logic [1:0] PHASE_STROBE_FIRST = 2'd1;
  localparam logic [1:0] PHASE_STROBE_LAST  = 2'd2;
  localparam logic [1:0] PHASE_HOLD         = 2'd3;

  localparam int FRAME_CYCLES = 16;

  function automatic logic is_strobe_phase(input logic [1:0] phase);
    return (phase == PHASE_STROBE_FIRST) || (phase == PHASE_STROBE_LAST);
  endfunction

endpackage

// File: rtl/ram_strobe.sv
// SRAM strobe decode shared by every slot: an active access drives exactly one
// of OE/WE low during the two strobe phases.
module ram_strobe
  import bus_pkg::*;
(
  input  logic [1:0] phase_i,
  input  logic       active_i,
  input  logic       we_i,
  output logic       ram_oe_n_o,
  output logic       ram_we_n_o
);

  logic strobe;

  always_comb begin
    strobe     = active_i && is_strobe_phase(phase_i);
    ram_oe_n_o = ~(strobe & ~we_i);
    ram_we_n_o = ~(strobe &  we_i);
  end

endmodule

// File: rtl/bus_scheduler.sv
// Fixed 16-cycle SRAM bus frame: video, SPI bridge and 6502 CPU slots.
// Define VIDEO_80COL_EN to turn slot 1 into a second video fetch instead of SPI1.
module bus_scheduler
  import bus_pkg::*;
(
  input  logic       clk_16_i,
  input  logic       reset_n_i,
  input  logic       spi_req_i,
  input  logic       spi_we_i,
  input  logic       cpu_we_i,
  output logic [1:0] bus_owner_o,
  output logic       ram_oe_n_o,
  output logic       ram_we_n_o,
  output logic       video_load_o,
  output logic       video_col_o,
  output logic       spi_ack_o,
  output logic       cpu_en_o
);

  logic       run_q, run_d;
  logic [3:0] cycle_q, cycle_d;
  logic       spi_active_q, spi_active_d;
  logic       we_q, we_d;

  logic [1:0] slot;
  logic [1:0] phase;
  logic       is_video;
  logic       is_spi;
  logic       strobe_active;
  logic       strobe_we;
  owner_t     owner;

  always_comb begin
    slot     = cycle_q[3:2];
    phase    = cycle_q[1:0];
    is_video = (slot == SLOT_VIDEO0);
    is_spi   = (slot == SLOT_SPI);
`ifdef VIDEO_80COL_EN
    if (slot == SLOT_1) is_video = 1'b1;
`else
    if (slot == SLOT_1) is_spi = 1'b1;
`endif
  end

  // Requests and write direction are sampled only at the setup phase of a slot.
  always_comb begin
    run_d        = 1'b1;
    cycle_d      = cycle_q;
    spi_active_d = spi_active_q;
    we_d         = we_q;
    if (run_q) begin
      cycle_d = (cycle_q == 4'(FRAME_CYCLES - 1)) ? 4'd0 : cycle_q + 4'd1;
      if (is_spi && (phase == PHASE_SETUP) && spi_req_i) begin
        spi_active_d = 1'b1;
        we_d         = spi_we_i;
      end
      if (is_spi && (phase == PHASE_HOLD)) spi_active_d = 1'b0;
      if ((slot == SLOT_CPU) && (phase == PHASE_SETUP)) we_d = cpu_we_i;
    end
  end

  always_ff @(posedge clk_16_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      run_q        <= 1'b0;
      cycle_q      <= 4'd0;
      spi_active_q <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      run_q        <= run_d;
      cycle_q      <= cycle_d;
      spi_active_q <= spi_active_d;
      we_q         <= we_d;
    end
  end

  // SPI slot shows the SPI owner during setup so the address mux is ready
  // if the request is granted; it falls back to NONE when nothing was sampled.
  always_comb begin
    owner         = OWNER_NONE;
    strobe_active = 1'b0;
    strobe_we     = 1'b0;
    video_load_o  = 1'b0;
    video_col_o   = 1'b0;
    spi_ack_o     = 1'b0;
    cpu_en_o      = 1'b0;
    if (run_q) begin
      if (is_video) begin
        owner         = OWNER_VIDEO;
        strobe_active = 1'b1;
        video_load_o  = (phase == PHASE_HOLD);
`ifdef VIDEO_80COL_EN
        video_col_o   = slot[0];
`endif
      end else if (is_spi) begin
        if ((phase == PHASE_SETUP) || spi_active_q) owner = OWNER_SPI;
        strobe_active = spi_active_q;
        strobe_we     = we_q;
        spi_ack_o     = spi_active_q && (phase == PHASE_HOLD);
      end else begin
        owner         = OWNER_CPU;
        strobe_active = 1'b1;
        strobe_we     = we_q;
        cpu_en_o      = (phase == PHASE_HOLD);
      end
    end
    bus_owner_o = owner;
  end

  ram_strobe u_ram_strobe (
    .phase_i    (phase),
    .active_i   (strobe_active),
    .we_i       (strobe_we),
    .ram_oe_n_o (ram_oe_n_o),
    .ram_we_n_o (ram_we_n_o)
  );

endmodule
